// File: rtl/dq_idelay_cal.sv
// Per-lane IDELAYE2 read-capture calibration: sweeps all 32 taps, records pass/fail per tap,
// then loads the centre of the longest passing window into each lane in turn.
module dq_idelay_cal #(
    parameter int W       = 8,
    parameter int SETTLE  = 16,
    parameter int SAMPLES = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            idelayctl_rdy,
    input  logic                            cmp_valid,
    input  logic                            cmp_ok,
    output logic [((W > 1) ? $clog2(W) : 1)-1:0] lane_sel,
    output logic [4:0]                      dly_cntvaluein,
    output logic [W-1:0]                    dly_ld,
    output logic                            busy,
    output logic                            done,
    output logic [W-1:0]                    cal_fail,
    output logic [5*W-1:0]                  tap_final
);

    localparam int LW = (W > 1) ? $clog2(W) : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int BW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_WAIT_RDY   = 4'd1;
    localparam logic [3:0] ST_LOAD       = 4'd2;
    localparam logic [3:0] ST_SETTLE     = 4'd3;
    localparam logic [3:0] ST_SAMPLE     = 4'd4;
    localparam logic [3:0] ST_EVAL       = 4'd5;
    localparam logic [3:0] ST_LOAD_FINAL = 4'd6;
    localparam logic [3:0] ST_NEXT_LANE  = 4'd7;
    localparam logic [3:0] ST_DONE       = 4'd8;

    logic [3:0]    state_q, state_d;
    logic [LW-1:0] lane_q;
    logic [4:0]    tap_q;
    logic [4:0]    cval_q;
    logic [SW-1:0] settle_cnt_q;
    logic [BW-1:0] beat_cnt_q;
    logic          ok_acc_q;
    logic [31:0]   pass_q;
    logic [5:0]    idx_q;
    logic [4:0]    run_start_q;
    logic [5:0]    run_len_q;
    logic [4:0]    best_start_q;
    logic [5:0]    best_len_q;
    logic [W-1:0]  cal_fail_q;
    logic [5*W-1:0] tap_final_q;

    logic          last_beat;
    logic [4:0]    center;

    assign last_beat = cmp_valid && (beat_cnt_q == BW'(SAMPLES - 1));
    // Centre biased low for even-length windows; cannot overflow because s + L - 1 <= 31.
    assign center = (best_len_q == 6'd0) ? 5'd0
                  : best_start_q + 5'((best_len_q - 6'd1) >> 1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_WAIT_RDY;
            ST_WAIT_RDY:      if (idelayctl_rdy) state_d = ST_LOAD;
            ST_LOAD:          state_d = ST_SETTLE;
            ST_SETTLE:        if (settle_cnt_q == SW'(SETTLE - 1)) state_d = ST_SAMPLE;
            ST_SAMPLE:        if (last_beat) state_d = (tap_q == 5'd31) ? ST_EVAL : ST_LOAD;
            ST_EVAL:          if (idx_q == 6'd32) state_d = ST_LOAD_FINAL;
            ST_LOAD_FINAL:    state_d = ST_NEXT_LANE;
            ST_NEXT_LANE:     state_d = (lane_q == LW'(W - 1)) ? ST_DONE : ST_WAIT_RDY;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            lane_q       <= '0;
            tap_q        <= '0;
            cval_q       <= '0;
            settle_cnt_q <= '0;
            beat_cnt_q   <= '0;
            ok_acc_q     <= 1'b1;
            pass_q       <= '0;
            idx_q        <= '0;
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            cal_fail_q   <= '0;
            tap_final_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        lane_q       <= '0;
                        tap_q        <= '0;
                        settle_cnt_q <= '0;
                        beat_cnt_q   <= '0;
                        ok_acc_q     <= 1'b1;
                        pass_q       <= '0;
                        idx_q        <= '0;
                        run_start_q  <= '0;
                        run_len_q    <= '0;
                        best_start_q <= '0;
                        best_len_q   <= '0;
                        cal_fail_q   <= '0;
                        tap_final_q  <= '0;
                    end
                end
                ST_WAIT_RDY: if (idelayctl_rdy) cval_q <= tap_q;
                ST_SETTLE: begin
                    settle_cnt_q <= (settle_cnt_q == SW'(SETTLE - 1)) ? '0 : settle_cnt_q + 1'b1;
                end
                ST_SAMPLE: begin
                    if (last_beat) begin
                        pass_q[tap_q] <= ok_acc_q & cmp_ok;
                        beat_cnt_q    <= '0;
                        ok_acc_q      <= 1'b1;
                        if (tap_q != 5'd31) begin
                            tap_q  <= tap_q + 5'd1;
                            cval_q <= tap_q + 5'd1;
                        end
                    end else if (cmp_valid) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        ok_acc_q   <= ok_acc_q & cmp_ok;
                    end
                end
                ST_EVAL: begin
                    if (idx_q != 6'd32) begin
                        idx_q <= idx_q + 6'd1;
                        if (pass_q[idx_q[4:0]]) begin
                            run_len_q <= run_len_q + 6'd1;
                            if (run_len_q == 6'd0) run_start_q <= idx_q[4:0];
                            // Strictly longer only, so the earliest window wins a tie.
                            if (run_len_q + 6'd1 > best_len_q) begin
                                best_len_q   <= run_len_q + 6'd1;
                                best_start_q <= (run_len_q == 6'd0) ? idx_q[4:0] : run_start_q;
                            end
                        end else begin
                            run_len_q <= '0;
                        end
                    end else begin
                        cval_q                    <= center;
                        tap_final_q[5*lane_q +: 5] <= center;
                        if (best_len_q == 6'd0) cal_fail_q[lane_q] <= 1'b1;
                    end
                end
                ST_NEXT_LANE: begin
                    if (lane_q != LW'(W - 1)) begin
                        lane_q       <= lane_q + 1'b1;
                        tap_q        <= '0;
                        pass_q       <= '0;
                        idx_q        <= '0;
                        run_start_q  <= '0;
                        run_len_q    <= '0;
                        best_start_q <= '0;
                        best_len_q   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign lane_sel       = lane_q;
    assign dly_cntvaluein = cval_q;
    assign dly_ld         = (state_q == ST_LOAD || state_q == ST_LOAD_FINAL)
                          ? (W'(1) << lane_q) : '0;
    assign busy           = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done           = (state_q == ST_DONE);
    assign cal_fail       = cal_fail_q;
    assign tap_final      = tap_final_q;

endmodule

// File: doc/dq_idelay_cal.md
DQ_IDELAY_CAL -- requirements
Module: dq_idelay_cal

Interface
REQ-001 Parameter W, default 8, meaning number of DRAM byte lanes calibrated.
REQ-002 Parameter SETTLE, default 16, meaning idle cycles after each tap load before sampling.
REQ-003 Parameter SAMPLES, default 64, meaning compare beats evaluated per tap.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle pulse that begins calibration of all lanes.
REQ-007 idelayctl_rdy  input  1  IDELAYCTRL ready; no tap load occurs while low.
REQ-008 cmp_valid  input  1  compare beat valid for the selected lane.
REQ-009 cmp_ok  input  1  selected-lane read data matched the expected pattern; qualified by cmp_valid.
REQ-010 lane_sel  output  $clog2(W) (min 1)  lane currently under calibration.
REQ-011 dly_cntvaluein  output  5  tap value driven to IDELAYE2 CNTVALUEIN of all lanes.
REQ-012 dly_ld  output  W  per-lane IDELAYE2 LD strobe (VAR_LOAD mode).
REQ-013 busy  output  1  calibration in progress.
REQ-014 done  output  1  calibration complete; held until next start or rst.
REQ-015 cal_fail  output  W  per-lane flag: no passing tap found.
REQ-016 tap_final  output  5*W  final tap per lane; lane n at bits [5n+4:5n].

Function
REQ-017 States: IDLE, WAIT_RDY, LOAD, SETTLE, SAMPLE, EVAL, LOAD_FINAL, NEXT_LANE, DONE.
REQ-018 IDLE/DONE -> WAIT_RDY on start; start ignored in any other state.
REQ-019 On entering WAIT_RDY from start: lane_sel=0, tap=0, done=0, cal_fail=0, tap_final=0.
REQ-020 WAIT_RDY -> LOAD when idelayctl_rdy=1; stays otherwise.
REQ-021 LOAD lasts exactly one cycle: dly_cntvaluein=tap, dly_ld[lane_sel]=1, all other dly_ld bits 0; then SETTLE.
REQ-022 dly_ld is 0 in every state except LOAD and LOAD_FINAL.
REQ-023 SETTLE counts exactly SETTLE cycles, cmp inputs ignored, then SAMPLE.
REQ-024 SAMPLE counts cmp_valid beats; leaves after SAMPLES-th valid beat; cmp_ok ignored when cmp_valid=0.
REQ-025 Tap passes iff cmp_ok=1 on all SAMPLES valid beats; result stored in 32-bit per-lane pass vector bit [tap].
REQ-026 After SAMPLE: tap<31 -> tap+1, LOAD; tap=31 -> EVAL (no 5-bit wrap to 0).
REQ-027 EVAL: find longest run of consecutive passing taps (start s, length L); ties resolved to lowest s; scan may take up to 33 cycles.
REQ-028 Center = s + floor((L-1)/2), 5-bit unsigned, never exceeds 31.
REQ-029 L=0: cal_fail[lane_sel]=1, final tap=0; L>=1: final tap=center.
REQ-030 LOAD_FINAL: one cycle, dly_cntvaluein=final tap, dly_ld[lane_sel]=1, tap_final lane field written same cycle; then NEXT_LANE.
REQ-031 NEXT_LANE: lane_sel<W-1 -> lane_sel+1, tap=0, pass vector cleared, WAIT_RDY; lane_sel=W-1 -> DONE.
REQ-032 DONE: done=1, busy=0, lane_sel and dly_cntvaluein hold last values.
REQ-033 busy=1 in all states except IDLE and DONE.
REQ-034 idelayctl_rdy dropping mid-lane has no effect until next WAIT_RDY.

Reset
REQ-035 rst=1 on a clk edge forces IDLE from any state, overriding start.
REQ-036 Reset values: lane_sel=0, dly_cntvaluein=0, dly_ld=0, busy=0, done=0, cal_fail=0, tap_final=0, counters and pass vectors 0.
REQ-037 rst mid-calibration issues no further dly_ld; a new start restarts from lane 0.

Verification
REQ-038 W=2, SETTLE=4, SAMPLES=8, cmp_valid=1 always, cmp_ok=1 only for taps 10..20 -> tap_final=15 both lanes, cal_fail=0, done=1; 33 dly_ld pulses per lane.
REQ-039 Lane 0 passes taps 2..5 and 12..19 -> s=12, L=8, tap_final[4:0]=15; runs 4..7 and 20..23 (tie) -> 5.
REQ-040 Lane 1 never passes -> cal_fail=2'b10, tap_final[9:5]=0, final LD with value 0, done=1.
REQ-041 idelayctl_rdy=0 for 50 cycles after start -> no dly_ld, busy=1, first LD (tap 0) one cycle after rdy rises.
REQ-042 cmp_valid every 3rd cycle -> SAMPLE lasts 24 cycles per tap; single cmp_ok=0 at tap 7 -> bit 7 fails.
REQ-043 rst asserted at lane 1 tap 9 -> next cycle IDLE, all outputs at reset values; start pulse during busy -> ignored.
